agc_regfile_mp: RTL and testbench

- Parametrised multi-port successor to the CPU register file for the AGC pipeline; holds A, L, Q, bank bits (EB/FB/BB), editing registers (CYR/SR/CYL/SL) and free-running timers TIME1/TIME2.
- Adds NWR write ports and NRD read ports with enable-qualified forwarding.
- TIME1 auto-increments on a tick and cascades its overflow into TIME2; TIME2 overflow raises an interrupt request with an acknowledge handshake.
- Sits in decode (reads) and writeback (writes); bits_EB/bits_FB feed address translation.

---
 rtl/agc_regfile_mp.sv | 181 ++++++++++++++++++
 tb/tb_agc_regfile_mp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/agc_regfile_mp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : agc_regfile_mp
// Description : Multi-port AGC CPU register file. Holds A/L/Q, bank bits
//               (EB/FB/BB), editing registers (CYR/SR/CYL/SL) and cascaded
//               timers TIME1/TIME2 with an overflow interrupt handshake.
//               Reads forward same-cycle software writes.
// Revision    : 1.0 - initial release
// ============================================================================
module agc_regfile_mp #(
  parameter int WIDTH    = 15,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int SEL_W    = 4,
  parameter int TIMER_EN = 1
) (
  input  logic                        clock,
  input  logic                        rst_l,
  input  logic [NWR-1:0]              wr_en,
  input  logic [NWR-1:0][SEL_W-1:0]   wr_sel,
  input  logic [NWR-1:0][WIDTH-1:0]   wr_data,
  input  logic [NRD-1:0][SEL_W-1:0]   rd_sel,
  output logic [NRD-1:0][WIDTH-1:0]   rd_data,
  output logic [2:0]                  bits_EB,
  output logic [2:0]                  bits_FB,
  input  logic                        tick,
  output logic                        t_irq,
  input  logic                        t_irq_ack
);

  localparam logic [SEL_W-1:0] c_sel_a     = SEL_W'(0);
  localparam logic [SEL_W-1:0] c_sel_l     = SEL_W'(1);
  localparam logic [SEL_W-1:0] c_sel_q     = SEL_W'(2);
  localparam logic [SEL_W-1:0] c_sel_eb    = SEL_W'(3);
  localparam logic [SEL_W-1:0] c_sel_fb    = SEL_W'(4);
  localparam logic [SEL_W-1:0] c_sel_bb    = SEL_W'(5);
  localparam logic [SEL_W-1:0] c_sel_cyr   = SEL_W'(7);
  localparam logic [SEL_W-1:0] c_sel_sr    = SEL_W'(8);
  localparam logic [SEL_W-1:0] c_sel_cyl   = SEL_W'(9);
  localparam logic [SEL_W-1:0] c_sel_sl    = SEL_W'(10);
  localparam logic [SEL_W-1:0] c_sel_time1 = SEL_W'(11);
  localparam logic [SEL_W-1:0] c_sel_time2 = SEL_W'(12);
  localparam logic             c_timer_en  = (TIMER_EN != 0);

  // Stored state; r_bb holds BB[14:9] (r_bb[2:0] = EB field, r_bb[5:3] = FB field)
  logic [WIDTH-1:0] r_a, r_l, r_q, r_cyr, r_sr, r_cyl, r_sl, r_time1, r_time2;
  logic [5:0]       r_bb;
  logic             r_irq;

  // State after software writes only (no tick); this is also the read view
  logic [WIDTH-1:0] w_sw_a, w_sw_l, w_sw_q, w_sw_cyr, w_sw_sr, w_sw_cyl, w_sw_sl;
  logic [WIDTH-1:0] w_sw_t1, w_sw_t2;
  logic [5:0]       w_sw_bb;
  logic             w_wr_t1, w_wr_t2;

  logic [WIDTH-1:0] w_t1_inc, w_t2_inc, w_nxt_t1, w_nxt_t2;
  logic             w_tick, w_t1_wrap, w_t2_wrap, w_t1_step, w_t2_step, w_irq_set;
  logic [WIDTH-1:0] w_eb_view, w_fb_view, w_bb_view;

  // Apply enabled write ports in index order so higher ports override lower ones
  always_comb begin
    w_sw_a   = r_a;
    w_sw_l   = r_l;
    w_sw_q   = r_q;
    w_sw_cyr = r_cyr;
    w_sw_sr  = r_sr;
    w_sw_cyl = r_cyl;
    w_sw_sl  = r_sl;
    w_sw_t1  = r_time1;
    w_sw_t2  = r_time2;
    w_sw_bb  = r_bb;
    w_wr_t1  = 1'b0;
    w_wr_t2  = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i]) begin
        case (wr_sel[i])
          c_sel_a:     w_sw_a   = wr_data[i];
          c_sel_l:     w_sw_l   = wr_data[i];
          c_sel_q:     w_sw_q   = wr_data[i];
          c_sel_eb:    w_sw_bb[2:0] = wr_data[i][11:9];
          c_sel_fb:    w_sw_bb[5:3] = wr_data[i][14:12];
          c_sel_bb:    w_sw_bb  = wr_data[i][14:9];
          c_sel_cyr:   w_sw_cyr = {wr_data[i][0], wr_data[i][WIDTH-1:1]};
          c_sel_sr:    w_sw_sr  = {wr_data[i][WIDTH-1], wr_data[i][WIDTH-1:1]};
          c_sel_cyl:   w_sw_cyl = {wr_data[i][WIDTH-2:0], wr_data[i][WIDTH-1]};
          c_sel_sl:    w_sw_sl  = {wr_data[i][WIDTH-2:0], 1'b0};
          c_sel_time1: begin
            w_sw_t1 = wr_data[i];
            w_wr_t1 = 1'b1;
          end
          c_sel_time2: begin
            w_sw_t2 = wr_data[i];
            w_wr_t2 = 1'b1;
          end
          default: ;  // ZERO and reserved codes are not writable
        endcase
      end
    end
  end

  // Timer cascade: a software write to a timer suppresses its increment and
  // everything downstream of it in the same cycle
  always_comb begin
    w_tick    = tick & c_timer_en;
    w_t1_wrap = (r_time1[13:0] == 14'h3FFF);
    w_t2_wrap = (r_time2[13:0] == 14'h3FFF);
    w_t1_step = w_tick & ~w_wr_t1;
    w_t2_step = w_t1_step & w_t1_wrap & ~w_wr_t2;
    w_irq_set = w_t2_step & w_t2_wrap;
    w_t1_inc  = '0;
    w_t2_inc  = '0;
    w_t1_inc[13:0] = r_time1[13:0] + 14'd1;
    w_t2_inc[13:0] = r_time2[13:0] + 14'd1;
    w_nxt_t1  = w_t1_step ? w_t1_inc : w_sw_t1;
    w_nxt_t2  = w_t2_step ? w_t2_inc : w_sw_t2;
  end

  // Read ports return the write-forwarded view; bank registers read as field views
  always_comb begin
    w_eb_view = '0;
    w_fb_view = '0;
    w_bb_view = '0;
    w_eb_view[11:9]  = w_sw_bb[2:0];
    w_fb_view[14:12] = w_sw_bb[5:3];
    w_bb_view[14:9]  = w_sw_bb;
    for (int j = 0; j < NRD; j++) begin
      case (rd_sel[j])
        c_sel_a:     rd_data[j] = w_sw_a;
        c_sel_l:     rd_data[j] = w_sw_l;
        c_sel_q:     rd_data[j] = w_sw_q;
        c_sel_eb:    rd_data[j] = w_eb_view;
        c_sel_fb:    rd_data[j] = w_fb_view;
        c_sel_bb:    rd_data[j] = w_bb_view;
        c_sel_cyr:   rd_data[j] = w_sw_cyr;
        c_sel_sr:    rd_data[j] = w_sw_sr;
        c_sel_cyl:   rd_data[j] = w_sw_cyl;
        c_sel_sl:    rd_data[j] = w_sw_sl;
        c_sel_time1: rd_data[j] = w_sw_t1;
        c_sel_time2: rd_data[j] = w_sw_t2;
        default:     rd_data[j] = '0;  // ZERO and reserved codes
      endcase
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      r_a     <= '0;
      r_l     <= '0;
      r_q     <= '0;
      r_cyr   <= '0;
      r_sr    <= '0;
      r_cyl   <= '0;
      r_sl    <= '0;
      r_time1 <= '0;
      r_time2 <= '0;
      r_bb    <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_a     <= w_sw_a;
      r_l     <= w_sw_l;
      r_q     <= w_sw_q;
      r_cyr   <= w_sw_cyr;
      r_sr    <= w_sw_sr;
      r_cyl   <= w_sw_cyl;
      r_sl    <= w_sw_sl;
      r_time1 <= w_nxt_t1;
      r_time2 <= w_nxt_t2;
      r_bb    <= w_sw_bb;
      // a fresh overflow outranks a simultaneous acknowledge
      r_irq   <= w_irq_set | (r_irq & ~t_irq_ack);
    end
  end

  assign bits_EB = r_bb[2:0];
  assign bits_FB = r_bb[5:3];
  assign t_irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_agc_regfile_mp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_agc_regfile_mp
// Description : Directed self-checking bench for agc_regfile_mp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_agc_regfile_mp;

  logic              clock = 1'b0;
  logic              rst_l = 1'b1;
  logic [1:0]        wr_en;
  logic [1:0][3:0]   wr_sel;
  logic [1:0][14:0]  wr_data;
  logic [1:0][3:0]   rd_sel;
  logic [1:0][14:0]  rd_data;
  logic [2:0]        bits_EB, bits_FB;
  logic              tick, t_irq, t_irq_ack;

  int checks = 0;
  int errors = 0;

  agc_regfile_mp #(.WIDTH(15), .NRD(2), .NWR(2), .SEL_W(4), .TIMER_EN(1)) dut (
    .clock(clock), .rst_l(rst_l),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .bits_EB(bits_EB), .bits_FB(bits_FB),
    .tick(tick), .t_irq(t_irq), .t_irq_ack(t_irq_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en     = '0;
    tick      = 1'b0;
    t_irq_ack = 1'b0;
  endtask

  task automatic wr(input int p, input logic [3:0] s, input logic [14:0] d);
    wr_en[p]   = 1'b1;
    wr_sel[p]  = s;
    wr_data[p] = d;
  endtask

  initial begin
    idle();
    wr_sel  = '0;
    wr_data = '0;
    rd_sel[0] = 4'd0;
    rd_sel[1] = 4'd12;

    // reset, with a write to L attempted while reset is held
    #1 rst_l = 1'b0;
    wr(0, 4'd1, 15'h7777);
    #1;
    chk("rst_rdA", rd_data[0], 15'h0000);
    chk("rst_rdT2", rd_data[1], 15'h0000);
    chk("rst_EB", bits_EB, 3'd0);
    chk("rst_FB", bits_FB, 3'd0);
    chk("rst_irq", t_irq, 1'b0);
    step(); idle();
    rd_sel[0] = 4'd1;
    #1 chk("rst_drop_L", rd_data[0], 15'h0000);
    rst_l = 1'b1;
    step();
    rd_sel[0] = 4'd0;
    #1 chk("post_rst_A", rd_data[0], 15'h0000);

    // editing registers
    wr(0, 4'd7, 15'h0001); rd_sel[0] = 4'd7;
    #1 chk("cyr_fwd", rd_data[0], 15'h4000);
    step(); idle();
    #1 chk("cyr_st", rd_data[0], 15'h4000);
    wr(0, 4'd8, 15'h4001); wr(1, 4'd9, 15'h4001);
    rd_sel[0] = 4'd8; rd_sel[1] = 4'd9;
    #1 chk("sr_fwd", rd_data[0], 15'h6000);
    chk("cyl_fwd", rd_data[1], 15'h0003);
    step(); idle();
    #1 chk("sr_st", rd_data[0], 15'h6000);
    chk("cyl_st", rd_data[1], 15'h0003);
    wr(0, 4'd10, 15'h4001); rd_sel[0] = 4'd10;
    step(); idle();
    #1 chk("sl_st", rd_data[0], 15'h0002);

    // same-register collision
    wr(0, 4'd0, 15'h1111); wr(1, 4'd0, 15'h2222); rd_sel[0] = 4'd0;
    #1 chk("coll_fwd", rd_data[0], 15'h2222);
    step(); idle();
    #1 chk("coll_st", rd_data[0], 15'h2222);
    wr(0, 4'd0, 15'h1111); wr(1, 4'd0, 15'h3333); wr_en[1] = 1'b0;
    #1 chk("dis_fwd", rd_data[0], 15'h1111);
    step(); idle();
    #1 chk("dis_st", rd_data[0], 15'h1111);

    // bank fields
    wr(0, 4'd3, 15'h0600); wr(1, 4'd4, 15'h5000); rd_sel[0] = 4'd5;
    #1 chk("ebfb_fwd", rd_data[0], 15'h5600);
    step(); idle();
    #1 chk("bits_EB", bits_EB, 3'b011);
    chk("bits_FB", bits_FB, 3'b101);
    chk("bb_st", rd_data[0], 15'h5600);
    rd_sel[0] = 4'd3; rd_sel[1] = 4'd4;
    #1 chk("eb_view", rd_data[0], 15'h0600);
    chk("fb_view", rd_data[1], 15'h5000);
    wr(0, 4'd5, 15'h7E00); wr(1, 4'd3, 15'h0200); rd_sel[0] = 4'd5;
    #1 chk("bb_eb_fwd", rd_data[0], 15'h7200);
    step(); idle();
    #1 chk("bb_eb_EB", bits_EB, 3'b001);
    chk("bb_eb_FB", bits_FB, 3'b111);
    wr(0, 4'd3, 15'h0E00); wr(1, 4'd5, 15'h0000);
    #1 chk("eb_bb_fwd", rd_data[0], 15'h0000);
    step(); idle();
    #1 chk("eb_bb_EB", bits_EB, 3'b000);

    // ZERO and reserved codes
    wr(0, 4'd6, 15'h7FFF); wr(1, 4'd13, 15'h7FFF);
    rd_sel[0] = 4'd6; rd_sel[1] = 4'd13;
    #1 chk("zero_fwd", rd_data[0], 15'h0000);
    chk("rsv_fwd", rd_data[1], 15'h0000);
    step(); idle();
    rd_sel[1] = 4'd0;
    #1 chk("zero_st", rd_data[0], 15'h0000);
    chk("A_kept", rd_data[1], 15'h1111);

    // double wrap raises irq
    rd_sel[0] = 4'd11; rd_sel[1] = 4'd12;
    wr(0, 4'd11, 15'h3FFF); wr(1, 4'd12, 15'h3FFF);
    step(); idle();
    tick = 1'b1;
    #1 chk("t1_nofwd", rd_data[0], 15'h3FFF);
    chk("t2_nofwd", rd_data[1], 15'h3FFF);
    chk("irq_pre", t_irq, 1'b0);
    step(); idle();
    #1 chk("wrap_t1", rd_data[0], 15'h0000);
    chk("wrap_t2", rd_data[1], 15'h0000);
    chk("wrap_irq", t_irq, 1'b1);

    // ack coinciding with a new overflow keeps irq pending
    wr(0, 4'd11, 15'h3FFF); wr(1, 4'd12, 15'h3FFF);
    step(); idle();
    tick = 1'b1; t_irq_ack = 1'b1;
    step(); idle();
    #1 chk("ack_wrap_irq", t_irq, 1'b1);
    chk("ack_wrap_t2", rd_data[1], 15'h0000);
    t_irq_ack = 1'b1;
    step(); idle();
    #1 chk("ack_irq", t_irq, 1'b0);
    t_irq_ack = 1'b1;
    step(); idle();
    #1 chk("ack_idle_irq", t_irq, 1'b0);

    // software TIME2 write beats cascade and suppresses irq
    wr(0, 4'd11, 15'h3FFF); wr(1, 4'd12, 15'h3FFF);
    step(); idle();
    tick = 1'b1; wr(1, 4'd12, 15'h3FFF);
    step(); idle();
    #1 chk("t2wr_t1", rd_data[0], 15'h0000);
    chk("t2wr_t2", rd_data[1], 15'h3FFF);
    chk("t2wr_irq", t_irq, 1'b0);

    // software TIME1 write beats tick and cascade
    wr(0, 4'd11, 15'h3FFF);
    step(); idle();
    tick = 1'b1; wr(0, 4'd11, 15'd100);
    #1 chk("t1wr_fwd", rd_data[0], 15'd100);
    step(); idle();
    #1 chk("t1wr_t1", rd_data[0], 15'd100);
    chk("t1wr_t2", rd_data[1], 15'h3FFF);
    chk("t1wr_irq", t_irq, 1'b0);
    tick = 1'b1;
    step(); idle();
    #1 chk("tick_inc", rd_data[0], 15'd101);

    // asynchronous reset mid-operation, tick dropped while held
    #2 rst_l = 1'b0;
    tick = 1'b1;
    #1 chk("mid_rst_t2", rd_data[1], 15'h0000);
    step();
    chk("mid_rst_t1", rd_data[0], 15'h0000);
    idle();
    rst_l = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
